// File: rtl/ili9341_parallel_8bit_rx_if.sv
// Bus bundle between an ILI9341 8080-style host and the parallel-write sink.
// master = LCD host side (drives the strobes), slave = the receiver.
interface ili9341_parallel_8bit_rx_if;
    logic        lcd_rst;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [7:0]  lcd_data;

    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_color;
    logic        frame_done;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        disp_on;
    logic        sleep_out;
    logic [7:0]  colmod;

    modport master (
        output lcd_rst, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data,
        input  pix_valid, pix_x, pix_y, pix_color, frame_done,
               cmd_valid, cmd_code, disp_on, sleep_out, colmod
    );

    modport slave (
        input  lcd_rst, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data,
        output pix_valid, pix_x, pix_y, pix_color, frame_done,
               cmd_valid, cmd_code, disp_on, sleep_out, colmod
    );
endinterface

// File: rtl/ili9341_parallel_8bit_rx.sv
// ILI9341 8-bit parallel write sink: synchronizes the host bus, decodes the
// command/parameter stream, tracks the address window and RAM write cursor,
// and emits one RGB565 pixel event per two data bytes.
module ili9341_parallel_8bit_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240
) (
    input logic                       clk,
    input logic                       reset,
    ili9341_parallel_8bit_rx_if.slave bus
);
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    localparam logic [15:0] EC_INIT     = 16'(WIDTH - 1);
    localparam logic [15:0] EP_INIT     = 16'(HEIGHT - 1);
    localparam logic [15:0] WIDTH_16    = 16'(WIDTH);
    localparam logic [15:0] HEIGHT_16   = 16'(HEIGHT);
    localparam logic [7:0]  COLMOD_INIT = 8'h66;

    localparam logic [1:0] SEL_CASET  = 2'd0;
    localparam logic [1:0] SEL_PASET  = 2'd1;
    localparam logic [1:0] SEL_COLMOD = 2'd2;

    typedef enum logic [1:0] {IDLE, PARAM, PIX_HI, PIX_LO} state_t;

    // Synchronizer chains; the last stage is the one the decoder sees.
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   wr_prev;

    logic       init;
    logic       byte_stb;
    logic       rs_s;
    logic [7:0] d_s;
    logic       unused_rd;

    state_t      state, state_nxt;
    logic [1:0]  par_sel, par_sel_nxt;
    logic [2:0]  par_idx, par_idx_nxt;
    logic [7:0]  par_b0, par_b0_nxt;
    logic [7:0]  par_b1, par_b1_nxt;
    logic [7:0]  par_b2, par_b2_nxt;
    logic [7:0]  pix_hi, pix_hi_nxt;
    logic [15:0] sc, sc_nxt, ec, ec_nxt, sp, sp_nxt, ep, ep_nxt;
    logic [15:0] cur_x, cur_x_nxt, cur_y, cur_y_nxt;

    logic        pix_valid, pix_valid_nxt;
    logic [8:0]  pix_x, pix_x_nxt, pix_y, pix_y_nxt;
    logic [15:0] pix_color, pix_color_nxt;
    logic        frame_done, frame_done_nxt;
    logic        cmd_valid, cmd_valid_nxt;
    logic [7:0]  cmd_code, cmd_code_nxt;
    logic        disp_on, disp_on_nxt;
    logic        sleep_out, sleep_out_nxt;
    logic [7:0]  colmod, colmod_nxt;

    assign unused_rd = bus.lcd_rd;

    // Control-line synchronizers idle at their inactive (high) level after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync  <= '1;
            wr_sync  <= '1;
            rst_sync <= '1;
            wr_prev  <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.lcd_cs};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus.lcd_wr};
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], bus.lcd_rst};
            wr_prev  <= wr_sync[SYNC_STAGES-1];
        end
    end

    // Data-path synchronizers, same depth as WR so the byte lines up with its strobe
    always_ff @(posedge clk) begin
        rs_sync      <= {rs_sync[SYNC_STAGES-2:0], bus.lcd_rs};
        data_sync[0] <= bus.lcd_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync[i] <= data_sync[i-1];
        end
    end

    assign init     = reset | ~rst_sync[SYNC_STAGES-1];
    assign byte_stb = wr_sync[SYNC_STAGES-1] & ~wr_prev & ~cs_sync[SYNC_STAGES-1];
    assign rs_s     = rs_sync[SYNC_STAGES-1];
    assign d_s      = data_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk) begin
        if (init) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: every command restarts the decoder; data bytes step the pixel pair
    always_comb begin
        state_nxt = state;
        if (byte_stb) begin
            if (!rs_s) begin
                case (d_s)
                    CMD_CASET, CMD_PASET, CMD_COLMOD: state_nxt = PARAM;
                    CMD_RAMWR, CMD_RAMWRC:            state_nxt = PIX_HI;
                    default:                          state_nxt = IDLE;
                endcase
            end else begin
                case (state)
                    PIX_HI:  state_nxt = PIX_LO;
                    PIX_LO:  state_nxt = PIX_HI;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // Output/datapath decode for the accepted byte
    always_comb begin
        par_sel_nxt    = par_sel;
        par_idx_nxt    = par_idx;
        par_b0_nxt     = par_b0;
        par_b1_nxt     = par_b1;
        par_b2_nxt     = par_b2;
        pix_hi_nxt     = pix_hi;
        sc_nxt         = sc;
        ec_nxt         = ec;
        sp_nxt         = sp;
        ep_nxt         = ep;
        cur_x_nxt      = cur_x;
        cur_y_nxt      = cur_y;
        pix_valid_nxt  = 1'b0;
        pix_x_nxt      = pix_x;
        pix_y_nxt      = pix_y;
        pix_color_nxt  = pix_color;
        frame_done_nxt = 1'b0;
        cmd_valid_nxt  = 1'b0;
        cmd_code_nxt   = cmd_code;
        disp_on_nxt    = disp_on;
        sleep_out_nxt  = sleep_out;
        colmod_nxt     = colmod;

        if (byte_stb) begin
            if (!rs_s) begin
                cmd_valid_nxt = 1'b1;
                cmd_code_nxt  = d_s;
                case (d_s)
                    CMD_CASET: begin
                        par_sel_nxt = SEL_CASET;
                        par_idx_nxt = 3'd0;
                    end
                    CMD_PASET: begin
                        par_sel_nxt = SEL_PASET;
                        par_idx_nxt = 3'd0;
                    end
                    CMD_COLMOD: begin
                        par_sel_nxt = SEL_COLMOD;
                        par_idx_nxt = 3'd0;
                    end
                    CMD_RAMWR: begin
                        cur_x_nxt = sc;
                        cur_y_nxt = sp;
                    end
                    CMD_SLPOUT:  sleep_out_nxt = 1'b1;
                    CMD_SLPIN:   sleep_out_nxt = 1'b0;
                    CMD_DISPON:  disp_on_nxt   = 1'b1;
                    CMD_DISPOFF: disp_on_nxt   = 1'b0;
                    CMD_SWRESET: begin
                        par_sel_nxt   = SEL_CASET;
                        par_idx_nxt   = 3'd0;
                        sc_nxt        = 16'd0;
                        ec_nxt        = EC_INIT;
                        sp_nxt        = 16'd0;
                        ep_nxt        = EP_INIT;
                        cur_x_nxt     = 16'd0;
                        cur_y_nxt     = 16'd0;
                        pix_x_nxt     = 9'd0;
                        pix_y_nxt     = 9'd0;
                        pix_color_nxt = 16'd0;
                        disp_on_nxt   = 1'b0;
                        sleep_out_nxt = 1'b0;
                        colmod_nxt    = COLMOD_INIT;
                    end
                    default: ;
                endcase
            end else begin
                case (state)
                    PARAM: begin
                        if (par_idx != 3'd4) par_idx_nxt = par_idx + 3'd1;
                        if (par_sel == SEL_COLMOD) begin
                            if (par_idx == 3'd0) colmod_nxt = d_s;
                        end else begin
                            case (par_idx)
                                3'd0: par_b0_nxt = d_s;
                                3'd1: par_b1_nxt = d_s;
                                3'd2: par_b2_nxt = d_s;
                                3'd3: begin
                                    // A reversed window is dropped, leaving the old one intact
                                    if ({par_b0, par_b1} <= {par_b2, d_s}) begin
                                        if (par_sel == SEL_CASET) begin
                                            sc_nxt = {par_b0, par_b1};
                                            ec_nxt = {par_b2, d_s};
                                        end else begin
                                            sp_nxt = {par_b0, par_b1};
                                            ep_nxt = {par_b2, d_s};
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    PIX_HI: pix_hi_nxt = d_s;
                    PIX_LO: begin
                        pix_x_nxt     = cur_x[8:0];
                        pix_y_nxt     = cur_y[8:0];
                        pix_color_nxt = {pix_hi, d_s};
                        pix_valid_nxt = (cur_x < WIDTH_16) && (cur_y < HEIGHT_16);
                        if (cur_x == ec) begin
                            cur_x_nxt = sc;
                            if (cur_y == ep) begin
                                cur_y_nxt      = sp;
                                frame_done_nxt = 1'b1;
                            end else begin
                                cur_y_nxt = cur_y + 16'd1;
                            end
                        end else begin
                            cur_x_nxt = cur_x + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Window, cursor and output registers, all returned to init state on reset
    always_ff @(posedge clk) begin
        if (init) begin
            par_sel    <= SEL_CASET;
            par_idx    <= 3'd0;
            sc         <= 16'd0;
            ec         <= EC_INIT;
            sp         <= 16'd0;
            ep         <= EP_INIT;
            cur_x      <= 16'd0;
            cur_y      <= 16'd0;
            pix_valid  <= 1'b0;
            pix_x      <= 9'd0;
            pix_y      <= 9'd0;
            pix_color  <= 16'd0;
            frame_done <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 8'h00;
            disp_on    <= 1'b0;
            sleep_out  <= 1'b0;
            colmod     <= COLMOD_INIT;
        end else begin
            par_sel    <= par_sel_nxt;
            par_idx    <= par_idx_nxt;
            sc         <= sc_nxt;
            ec         <= ec_nxt;
            sp         <= sp_nxt;
            ep         <= ep_nxt;
            cur_x      <= cur_x_nxt;
            cur_y      <= cur_y_nxt;
            pix_valid  <= pix_valid_nxt;
            pix_x      <= pix_x_nxt;
            pix_y      <= pix_y_nxt;
            pix_color  <= pix_color_nxt;
            frame_done <= frame_done_nxt;
            cmd_valid  <= cmd_valid_nxt;
            cmd_code   <= cmd_code_nxt;
            disp_on    <= disp_on_nxt;
            sleep_out  <= sleep_out_nxt;
            colmod     <= colmod_nxt;
        end
    end

    // Parameter shadow bytes and the pending high pixel byte carry no reset
    always_ff @(posedge clk) begin
        par_b0 <= par_b0_nxt;
        par_b1 <= par_b1_nxt;
        par_b2 <= par_b2_nxt;
        pix_hi <= pix_hi_nxt;
    end

    assign bus.pix_valid  = pix_valid;
    assign bus.pix_x      = pix_x;
    assign bus.pix_y      = pix_y;
    assign bus.pix_color  = pix_color;
    assign bus.frame_done = frame_done;
    assign bus.cmd_valid  = cmd_valid;
    assign bus.cmd_code   = cmd_code;
    assign bus.disp_on    = disp_on;
    assign bus.sleep_out  = sleep_out;
    assign bus.colmod     = colmod;
endmodule

// File: tb/tb_ili9341_parallel_8bit_rx.sv
// Testbench for ili9341_parallel_8bit_rx: directed scenarios plus a random
// command/data stream, compared byte-by-byte against a queue-based model.
module tb_ili9341_parallel_8bit_rx;
    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;

    localparam int SINK_NONE   = 0;
    localparam int SINK_CASET  = 1;
    localparam int SINK_PASET  = 2;
    localparam int SINK_COLMOD = 3;
    localparam int SINK_RAM    = 4;

    logic clk = 1'b0;
    logic reset;

    ili9341_parallel_8bit_rx_if bus ();

    ili9341_parallel_8bit_rx #(
        .SYNC_STAGES(2),
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Pulse-cycle counters sampled mid-cycle
    int pv_cnt = 0;
    int fd_cnt = 0;
    int cv_cnt = 0;
    always @(negedge clk) begin
        if (bus.pix_valid)  pv_cnt <= pv_cnt + 1;
        if (bus.frame_done) fd_cnt <= fd_cnt + 1;
        if (bus.cmd_valid)  cv_cnt <= cv_cnt + 1;
    end

    // Reference model state
    logic [15:0] m_sc, m_ec, m_sp, m_ep, m_cx, m_cy;
    int          m_sink;
    logic [7:0]  pq[$];
    logic [7:0]  pixq[$];
    logic [8:0]  m_pix_x, m_pix_y;
    logic [15:0] m_pix_color;
    logic [7:0]  m_cmd_code, m_colmod;
    logic        m_disp_on, m_sleep_out;
    int          exp_pv, exp_fd, exp_cv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_sc = 16'd0; m_ec = 16'(WIDTH - 1);
        m_sp = 16'd0; m_ep = 16'(HEIGHT - 1);
        m_cx = 16'd0; m_cy = 16'd0;
        m_sink = SINK_NONE;
        pq.delete();
        pixq.delete();
        m_pix_x = 9'd0; m_pix_y = 9'd0; m_pix_color = 16'd0;
        m_cmd_code = 8'h00; m_colmod = 8'h66;
        m_disp_on = 1'b0; m_sleep_out = 1'b0;
    endtask

    task automatic model_byte(input logic rs, input logic [7:0] d, input logic cs_n);
        logic [15:0] s, e;
        exp_pv = 0; exp_fd = 0; exp_cv = 0;
        if (cs_n) return;
        if (!rs) begin
            exp_cv = 1;
            pq.delete();
            pixq.delete();
            m_sink = SINK_NONE;
            case (d)
                8'h01: model_init();
                8'h2A: m_sink = SINK_CASET;
                8'h2B: m_sink = SINK_PASET;
                8'h3A: m_sink = SINK_COLMOD;
                8'h2C: begin m_cx = m_sc; m_cy = m_sp; m_sink = SINK_RAM; end
                8'h3C: m_sink = SINK_RAM;
                8'h11: m_sleep_out = 1'b1;
                8'h10: m_sleep_out = 1'b0;
                8'h29: m_disp_on = 1'b1;
                8'h28: m_disp_on = 1'b0;
                default: ;
            endcase
            m_cmd_code = d;
        end else begin
            case (m_sink)
                SINK_CASET, SINK_PASET: begin
                    pq.push_back(d);
                    if (pq.size() == 4) begin
                        s = {pq[0], pq[1]};
                        e = {pq[2], pq[3]};
                        if (s <= e) begin
                            if (m_sink == SINK_CASET) begin m_sc = s; m_ec = e; end
                            else begin m_sp = s; m_ep = e; end
                        end
                    end
                end
                SINK_COLMOD: begin
                    if (pq.size() == 0) m_colmod = d;
                    pq.push_back(d);
                end
                SINK_RAM: begin
                    pixq.push_back(d);
                    if (pixq.size() == 2) begin
                        m_pix_x = m_cx[8:0];
                        m_pix_y = m_cy[8:0];
                        m_pix_color = {pixq[0], pixq[1]};
                        exp_pv = (int'(m_cx) < WIDTH && int'(m_cy) < HEIGHT) ? 1 : 0;
                        if (m_cx == m_ec) begin
                            m_cx = m_sc;
                            if (m_cy == m_ep) begin
                                m_cy = m_sp;
                                exp_fd = 1;
                            end else begin
                                m_cy = m_cy + 16'd1;
                            end
                        end else begin
                            m_cx = m_cx + 16'd1;
                        end
                        pixq.delete();
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk_static(input string where);
        chk({where, ".pix_x"},     32'(bus.pix_x),     32'(m_pix_x));
        chk({where, ".pix_y"},     32'(bus.pix_y),     32'(m_pix_y));
        chk({where, ".pix_color"}, 32'(bus.pix_color), 32'(m_pix_color));
        chk({where, ".cmd_code"},  32'(bus.cmd_code),  32'(m_cmd_code));
        chk({where, ".disp_on"},   32'(bus.disp_on),   32'(m_disp_on));
        chk({where, ".sleep_out"}, 32'(bus.sleep_out), 32'(m_sleep_out));
        chk({where, ".colmod"},    32'(bus.colmod),    32'(m_colmod));
    endtask

    // One host write cycle, then check pulses seen and static outputs
    task automatic wr_byte(input logic rs, input logic [7:0] d, input logic cs_n);
        int pv0, fd0, cv0;
        @(negedge clk);
        pv0 = pv_cnt; fd0 = fd_cnt; cv0 = cv_cnt;
        bus.lcd_cs   = cs_n;
        bus.lcd_rs   = rs;
        bus.lcd_data = d;
        bus.lcd_wr   = 1'b0;
        bus.lcd_rd   = cs_n ? 1'b0 : 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_wr = 1'b1;
        bus.lcd_rd = 1'b1;
        model_byte(rs, d, cs_n);
        repeat (6) @(negedge clk);
        chk("pix_valid_pulses",  32'(pv_cnt - pv0), 32'(exp_pv));
        chk("frame_done_pulses", 32'(fd_cnt - fd0), 32'(exp_fd));
        chk("cmd_valid_pulses",  32'(cv_cnt - cv0), 32'(exp_cv));
        chk_static("byte");
    endtask

    task automatic cmd(input logic [7:0] d);
        wr_byte(1'b0, d, 1'b0);
    endtask

    task automatic dat(input logic [7:0] d);
        wr_byte(1'b1, d, 1'b0);
    endtask

    task automatic window(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        cmd(c);
        dat(s[15:8]); dat(s[7:0]); dat(e[15:8]); dat(e[7:0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s, e;
        logic [7:0]  pb [6];
        int          n, kind;

        bus.lcd_rst = 1'b1; bus.lcd_cs = 1'b1; bus.lcd_rs = 1'b0;
        bus.lcd_wr = 1'b1; bus.lcd_rd = 1'b1; bus.lcd_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_init();
        chk("rst.pix_valid",  32'(bus.pix_valid),  32'd0);
        chk("rst.cmd_valid",  32'(bus.cmd_valid),  32'd0);
        chk("rst.frame_done", 32'(bus.frame_done), 32'd0);
        chk_static("rst");

        // Default window: first pixel at (0,0), wrap at x=319 onto the next row
        cmd(8'h2C);
        for (int i = 0; i < 322; i++) begin
            dat(8'($urandom)); dat(8'($urandom));
        end

        // 3x2 window, frame_done on the last pixel, 7th pixel back at the start
        window(8'h2A, 16'd10, 16'd12);
        window(8'h2B, 16'd5, 16'd6);
        cmd(8'h2C);
        for (int i = 0; i < 7; i++) begin
            dat(8'hF8); dat(8'h00);
        end

        // Half pixel discarded by an intervening command, RAMWRC keeps cursor
        cmd(8'h2C); dat(8'hF8); cmd(8'h00); cmd(8'h3C); dat(8'h07); dat(8'hE0);

        // Reversed and incomplete windows are not committed
        window(8'h2A, 16'h0020, 16'h0010);
        cmd(8'h2A); dat(8'h00); dat(8'h01);
        cmd(8'h2C); dat(8'h12); dat(8'h34);

        // Window straddling the right edge
        window(8'h2A, 16'd318, 16'd321);
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) begin
            dat(8'h5A); dat(8'hA5);
        end

        // Mode flags, ignored strobes with cs high, then LCD hardware reset
        cmd(8'h11); cmd(8'h29); cmd(8'h3A); dat(8'h55);
        wr_byte(1'b0, 8'h28, 1'b1);
        wr_byte(1'b0, 8'h01, 1'b1);
        wr_byte(1'b1, 8'h77, 1'b1);
        @(negedge clk);
        bus.lcd_rst = 1'b0;
        repeat (4) @(negedge clk);
        bus.lcd_rst = 1'b1;
        repeat (6) @(negedge clk);
        model_init();
        chk_static("lcd_rst");
        cmd(8'h3C); dat(8'h01); dat(8'h02);

        // SWRESET after changing state
        window(8'h2B, 16'd7, 16'd9);
        cmd(8'h29); cmd(8'h01);
        cmd(8'h2C); dat(8'hAB); dat(8'hCD);

        // Random command/parameter/data stream
        for (int it = 0; it < 200; it++) begin
            kind = $urandom_range(0, 11);
            case (kind)
                0, 1, 2: begin
                    if (kind == 2) s = 16'($urandom_range(0, 245));
                    else           s = 16'($urandom_range(0, 330));
                    e = ($urandom_range(0, 4) == 0) ? s - 16'd1 : s + 16'($urandom_range(0, 3));
                    pb[0] = s[15:8]; pb[1] = s[7:0]; pb[2] = e[15:8]; pb[3] = e[7:0];
                    pb[4] = 8'($urandom); pb[5] = 8'($urandom);
                    n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : 4;
                    cmd((kind == 2) ? 8'h2B : 8'h2A);
                    for (int i = 0; i < n; i++) dat(pb[i]);
                end
                3, 4, 5: begin
                    cmd((kind == 5) ? 8'h3C : 8'h2C);
                    n = $urandom_range(0, 9);
                    for (int i = 0; i < n; i++) dat(8'($urandom));
                end
                6: begin
                    cmd(8'h3A);
                    n = $urandom_range(0, 2);
                    for (int i = 0; i < n; i++) dat(8'($urandom));
                end
                7: begin
                    pb[0] = 8'h11; pb[1] = 8'h10; pb[2] = 8'h29; pb[3] = 8'h28;
                    cmd(pb[$urandom_range(0, 3)]);
                end
                8: cmd(8'($urandom));
                9: dat(8'($urandom));
                10: wr_byte(1'($urandom), 8'($urandom), 1'b1);
                default: begin
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) dat(8'($urandom));
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ili9341_parallel_8bit_rx.md
Name: ili9341_parallel_8bit_rx

Overview:
Device-side model of the ILI9341 8080-style 8-bit parallel write interface: samples LCD_CS/RS/WR/RD/RST/D[7:0] as driven by the LCD host and decodes the command/parameter stream. Tracks the column/page address window and the RAM write cursor, and emits one RGB565 pixel-write event per two data bytes. Used as an FPGA-side LCD sink (capture into a frame buffer) and as the bus checker in host-driver simulations.

Parameters:
SYNC_STAGES, 2, synchronizer depth for all bus inputs (>=2)
WIDTH, 320, visible columns; pixel events with x >= WIDTH are suppressed
HEIGHT, 240, visible rows; pixel events with y >= HEIGHT are suppressed

Ports:
clk  in  1  system clock, >= 4x the host strobe rate
reset  in  1  synchronous, active-high
lcd_rst  in  1  LCD hardware reset, active-low, async (synchronized)
lcd_cs  in  1  chip select, active-low, async
lcd_rs  in  1  0 = command byte, 1 = parameter/data byte
lcd_wr  in  1  write strobe, byte latched on rising edge
lcd_rd  in  1  read strobe (ignored)
lcd_data  in  8  bus data
pix_valid  out  1  one-cycle pixel-write pulse
pix_x  out  9  pixel column
pix_y  out  9  pixel row
pix_color  out  16  RGB565 {first byte, second byte}
frame_done  out  1  one-cycle pulse with the pixel that completes the window
cmd_valid  out  1  one-cycle pulse per command byte accepted
cmd_code  out  8  last command byte
disp_on  out  1  display-on flag
sleep_out  out  1  sleep-out flag
colmod  out  8  last COLMOD value (stored only; format is always 16 bpp)

Behaviour:
- Clocking/reset: single clk. reset, synced lcd_rst==0, or the SWRESET command set the init state: all pulses 0, pix_x/pix_y/pix_color 0, cmd_code 0x00, disp_on 0, sleep_out 0, colmod 0x66, SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1, cursor=(0,0), FSM IDLE. SWRESET still pulses cmd_valid with cmd_code=0x01.
- Input capture: cs, rs, wr, and data each pass through SYNC_STAGES flops. A byte is accepted in the cycle where synced wr goes 0->1 while synced cs==0. Bytes are processed in that cycle and all outputs are registered. pix_valid/cmd_valid rise SYNC_STAGES+1 clk edges after the first edge that samples lcd_wr high.
- Host timing requirement: data/rs/cs stable from >= 1 clk before the WR rise to >= SYNC_STAGES clk after it. WR low >= 2 clk and high >= 2 clk. Violations are undefined.
- rs==0 (command): pulse cmd_valid, latch cmd_code. Any in-progress parameter or pixel sequence is abandoned, and a half pixel is discarded.
  - 0x2A CASET, 0x2B PASET, 0x3A COLMOD: enter PARAM with byte index 0.
  - 0x2C RAMWR: cursor=(SC,SP), enter PIX_HI.
  - 0x3C RAMWRC: cursor unchanged, enter PIX_HI.
  - 0x11 sleep_out=1; 0x10 sleep_out=0; 0x29 disp_on=1; 0x28 disp_on=0.
  - 0x01 SWRESET: init state as above.
  - All other codes, including 0x00: IDLE, no effect.
- rs==1 (parameter), by state:
  - IDLE: ignored.
  - PARAM/CASET, PARAM/PASET: bytes 0..3 are start[15:8], start[7:0], end[15:8], end[7:0], shadowed. Commit to SC/EC (SP/EP) only on byte 3 and only if start <= end; otherwise the registers are unchanged. Bytes after 3 are ignored. An incomplete sequence is never committed.
  - PARAM/COLMOD: byte 0 -> colmod; later bytes ignored.
  - PIX_HI: store byte, go to PIX_LO.
  - PIX_LO: emit pixel at the cursor with color {hi,lo}, then go to PIX_HI.
    - pix_valid=1 only if x<WIDTH and y<HEIGHT. pix_x/pix_y/pix_color update regardless.
    - Cursor advance: if x==EC then x=SC and y advances (if y==EP then y=SP and frame_done=1 in the same cycle as the pixel); else x+1.
    - Cursor/window registers are 16 bits; pix_x/pix_y are the low 9 bits.
- lcd_rd strobes and RD activity are ignored. Bytes with cs high are ignored, and the FSM state is held across cs deassertion.

Test Plan:
- Assert reset 3 cycles -> pix_valid=0, cmd_code=0x00, disp_on=0, sleep_out=0, colmod=0x66; SC/EC/SP/EP = 0/319/0/239 (checked via RAMWR+pixel at (0,0) and wrap at (319,n)).
- CASET 00 0A 00 0C, PASET 00 05 00 06, RAMWR 2C, 7 pixels F8 00 -> pix_valid at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) with pix_color 0xF800; frame_done only with (12,6); 7th pixel at (10,5).
- RAMWR, data F8, then command 0x00, then RAMWRC, data 07 E0 -> no pixel from F8; single pixel 0x07E0 at the cursor (SC,SP).
- CASET 00 20 00 10 (start>end), and separately CASET 00 01 then RAMWR -> window unchanged in both cases; RAMWR starts at previous SC.
- CASET 01 3E 01 41, RAMWR, 4 pixels -> pix_valid at x=318,319 only; x=320,321 suppressed; cursor wraps to 318.
- Commands 11, 29, 3A 55 -> sleep_out=1, disp_on=1, colmod=0x55. Then WR strobes with cs=1 -> no cmd_valid. Then lcd_rst low 4 clk -> all back to init values.
